// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store at a time, stalls
// the MEM stage for LATENCY+1 cycles, then presents the result for one DONE cycle.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t                state;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [31:0]           wdata;
  logic                  op_write;
  logic [31:0]           mem [2**ADDR_WIDTH];

  logic req;
  logic illegal;
  logic mem_we;

  assign req     = MemRead | MemWrite;
  // Anything above the word-address field must be zero: no aliasing.
  assign illegal = (addr[1:0] != 2'b00) | (MemRead & MemWrite) |
                   ((addr >> (ADDR_WIDTH + 2)) != '0);

  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = req;
      BUSY:    stall = 1'b1;
      DONE:    stall = 1'b0;
      default: stall = 1'b0;
    endcase
  end

  // Async reset forces IDLE before the edge, so an aborted store never lands.
  assign mem_we = (state == BUSY) && (cnt == '0) && op_write;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      read_data <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      op_write  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (illegal) begin
              err   <= 1'b1;
              state <= DONE;
            end else begin
              waddr    <= addr[ADDR_WIDTH+1:2];
              wdata    <= write_data;
              op_write <= MemWrite;
              cnt      <= CNT_INIT;
              busy     <= 1'b1;
              state    <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!op_write) begin
              read_data <= mem[waddr];
            end
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          err   <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
